// File: rtl/cvp14_core.sv
// cvp14_core -- multicycle 16-bit scalar/short-vector processor (CVP14 subset).
//
// Instructions are fetched from, and data moved to/from, one unified
// synchronous memory over a single RD/WR/Addr/Data bus. The core holds
// eight scalar registers R0-R7 and eight vector registers V0-V7, each
// vector register being VLEN (=4) elements of 16 bits.
//
// Ports:
//   Clk1     in   1   system clock, all state changes on the rising edge
//   Reset    in   1   asynchronous active-low reset
//   DataIn   in  16   read data, valid the cycle after RD was asserted
//   Addr     out 16   memory address
//   RD       out  1   memory read strobe
//   WR       out  1   memory write strobe (written at the end of the cycle)
//   DataOut  out 16   memory write data
//   V        out  1   signed-overflow flag of the last ADD/VADD
//
// Build option:
//   CVP14_SATURATE_EN  when defined, ADD/VADD results clamp to 16'h7FFF or
//                      16'h8000 on overflow instead of wrapping.

module cvp14_core #(
  parameter int          VLEN     = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] DataIn,
  output logic [15:0] Addr,
  output logic        RD,
  output logic        WR,
  output logic [15:0] DataOut,
  output logic        V
);

  localparam int            EW        = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam logic [EW-1:0] ELEM_LAST = EW'(VLEN - 1);

`ifdef CVP14_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_VADD = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLH  = 4'b0011;
  localparam logic [3:0] OP_LD   = 4'b0100;
  localparam logic [3:0] OP_ST   = 4'b0101;
  localparam logic [3:0] OP_VLD  = 4'b0110;
  localparam logic [3:0] OP_VST  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BOV  = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_HALT
  } state_t;

  state_t        state, next_state;
  logic [15:0]   pc;
  logic [15:0]   ir;
  logic [EW-1:0] elem;
  logic [15:0]   sreg [8];
  logic [15:0]   vreg [8][VLEN];
  logic          vflag;

  logic [3:0]    opcode;
  logic [2:0]    rd_f, rs_f, rt_f;
  logic [15:0]   imm6_sx, imm12_sx, mem_addr;

  logic [16:0]      add_r;
  logic [15:0]      vsum [VLEN];
  logic [VLEN-1:0]  vovf;

  assign opcode   = ir[15:12];
  assign rd_f     = ir[11:9];
  assign rs_f     = ir[8:6];
  assign rt_f     = ir[5:3];
  assign imm6_sx  = {{10{ir[5]}}, ir[5:0]};
  assign imm12_sx = {{4{ir[11]}}, ir[11:0]};
  assign V        = vflag;

  // Two's-complement add returning {overflow, result}; the result is either
  // wrapped or clamped depending on the build option.
  function automatic logic [16:0] add16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sum;
    logic        ovf;
    sum = a + b;
    ovf = (a[15] == b[15]) && (sum[15] != a[15]);
    if (SATURATE && ovf)
      sum = a[15] ? 16'h8000 : 16'h7FFF;
    return {ovf, sum};
  endfunction

  // Effective data address: scalar accesses use base + signed imm6, vector
  // accesses walk base + element index.
  always_comb begin
    mem_addr = sreg[rs_f] + imm6_sx;
    if (opcode == OP_VLD || opcode == OP_VST)
      mem_addr = sreg[rs_f] + 16'(elem);
  end

  // Scalar and per-element vector adders, computed from the current register
  // values so a destination equal to a source still sees the old operand.
  always_comb begin
    vovf  = '0;
    add_r = add16(sreg[rs_f], sreg[rt_f]);
    for (int k = 0; k < VLEN; k++) begin
      vsum[k] = '0;
      {vovf[k], vsum[k]} = add16(vreg[rs_f][k], vreg[rt_f][k]);
    end
  end

  // State register.
  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset)
      state <= S_FETCH;
    else
      state <= next_state;
  end

  // Next-state and bus outputs. The opcode is taken straight from DataIn in
  // DECODE because IR is only loaded at the end of that cycle. The bus is
  // forced idle while reset is held.
  always_comb begin
    next_state = state;
    RD         = 1'b0;
    WR         = 1'b0;
    Addr       = 16'h0000;
    DataOut    = 16'h0000;
    case (state)
      S_FETCH: begin
        RD         = 1'b1;
        Addr       = pc;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        case (DataIn[15:12])
          OP_LD, OP_VLD: next_state = S_MEMRD;
          OP_ST, OP_VST: next_state = S_MEMWR;
          OP_HALT:       next_state = S_HALT;
          default:       next_state = S_EXEC;
        endcase
      end
      S_EXEC: next_state = S_FETCH;
      S_MEMRD: begin
        RD         = 1'b1;
        Addr       = mem_addr;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        if (opcode == OP_VLD && elem != ELEM_LAST)
          next_state = S_MEMRD;
        else
          next_state = S_FETCH;
      end
      S_MEMWR: begin
        WR      = 1'b1;
        Addr    = mem_addr;
        DataOut = (opcode == OP_VST) ? vreg[rd_f][elem] : sreg[rd_f];
        if (opcode == OP_VST && elem != ELEM_LAST)
          next_state = S_MEMWR;
        else
          next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
    if (!Reset) begin
      RD      = 1'b0;
      WR      = 1'b0;
      Addr    = 16'h0000;
      DataOut = 16'h0000;
    end
  end

  // Datapath: PC, IR, element counter, register files and overflow flag.
  // PC is bumped in DECODE, so J/BOV targets are PC+1+imm12 by simply adding
  // the offset in EXEC.
  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      pc    <= RESET_PC;
      ir    <= 16'h0000;
      elem  <= '0;
      vflag <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        sreg[i] <= 16'h0000;
        for (int k = 0; k < VLEN; k++)
          vreg[i][k] <= 16'h0000;
      end
    end else begin
      case (state)
        S_DECODE: begin
          ir   <= DataIn;
          pc   <= pc + 16'd1;
          elem <= '0;
        end
        S_EXEC: begin
          case (opcode)
            OP_ADD: begin
              sreg[rd_f] <= add_r[15:0];
              vflag      <= add_r[16];
            end
            OP_VADD: begin
              for (int k = 0; k < VLEN; k++)
                vreg[rd_f][k] <= vsum[k];
              vflag <= |vovf;
            end
            OP_SLL: sreg[rd_f] <= {sreg[rd_f][15:8], ir[7:0]};
            OP_SLH: sreg[rd_f] <= {ir[7:0], sreg[rd_f][7:0]};
            OP_J:   pc <= pc + imm12_sx;
            OP_BOV: if (vflag) pc <= pc + imm12_sx;
            default: ;
          endcase
        end
        S_MEMWB: begin
          if (opcode == OP_VLD)
            vreg[rd_f][elem] <= DataIn;
          else
            sreg[rd_f] <= DataIn;
          elem <= elem + 1'b1;
        end
        S_MEMWR: elem <= elem + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cvp14_core.sv
// tb_cvp14_core -- self-checking bench for cvp14_core.
//
// The bench models the synchronous DRAM, loads small programs, and keeps a
// scoreboard of the memory writes each program must produce (address, data
// and the cycle, counted from reset release, in which WR is seen).

module tb_cvp14_core;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_VADD = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLH  = 4'b0011;
  localparam logic [3:0] OP_LD   = 4'b0100;
  localparam logic [3:0] OP_ST   = 4'b0101;
  localparam logic [3:0] OP_VLD  = 4'b0110;
  localparam logic [3:0] OP_VST  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BOV  = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

`ifdef CVP14_SATURATE_EN
  localparam logic [15:0] OVF_RESULT = 16'h7FFF;
`else
  localparam logic [15:0] OVF_RESULT = 16'h8000;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic        Clk1 = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] DataIn;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic [15:0] DataOut;
  logic        V;

  logic [15:0] mem [0:65535];
  logic [15:0] rdata = 16'h0000;
  int          cyc = 0;
  int          lastRdCyc = -1;
  int          checks = 0;
  int          failures = 0;
  wr_t         sbq [$];
  wr_t         monEntry;

  cvp14_core dut (
    .Clk1   (Clk1),
    .Reset  (Reset),
    .DataIn (DataIn),
    .Addr   (Addr),
    .RD     (RD),
    .WR     (WR),
    .DataOut(DataOut),
    .V      (V)
  );

  assign DataIn = rdata;

  always #5 Clk1 = ~Clk1;

  // Synchronous memory: read data appears the cycle after RD, writes land
  // at the edge closing the WR cycle. Also counts cycles since reset release.
  always @(posedge Clk1) begin
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;
    if (RD) rdata <= mem[Addr];
    if (WR) mem[Addr] = DataOut;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus monitor: remembers the last read cycle and compares every write
  // against the head of the scoreboard.
  always @(negedge Clk1) begin
    if (Reset) begin
      if (RD) lastRdCyc = cyc;
      if (WR) begin
        checkOutput("sb_pending", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
          monEntry = sbq.pop_front();
          checkOutput("wr_addr", 32'(Addr), 32'(monEntry.addr));
          checkOutput("wr_data", 32'(DataOut), 32'(monEntry.data));
          checkOutput("wr_cycle", 32'(cyc), 32'(monEntry.cyc));
        end
      end
    end
  end

  function automatic logic [15:0] encR(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s, input logic [2:0] t);
    return {op, d, s, t, 3'b000};
  endfunction

  function automatic logic [15:0] encI8(input logic [3:0] op, input logic [2:0] d, input logic [7:0] imm);
    return {op, d, 1'b0, imm};
  endfunction

  function automatic logic [15:0] encM(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s, input logic [5:0] imm);
    return {op, d, s, imm};
  endfunction

  function automatic logic [15:0] encJ(input logic [3:0] op, input logic [11:0] imm);
    return {op, imm};
  endfunction

  task automatic pushWrite(input logic [15:0] a, input logic [15:0] d, input int c);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  task automatic clearProg();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
  endtask

  // Holds reset for two edges, releases it just after an edge (so that edge
  // starts cycle 0), then lets the core run for the given number of cycles.
  task automatic applyStimulus(input int runCycles);
    Reset     = 1'b0;
    lastRdCyc = -1;
    @(posedge Clk1);
    @(posedge Clk1);
    #1 Reset = 1'b1;
    repeat (runCycles) @(posedge Clk1);
    #2;
  endtask

  // Shared prefix: R1=7FFF, R2=0001, R3=R1+R2 (overflows), 12 cycles.
  task automatic loadOverflowPrefix();
    mem[0] = encI8(OP_SLL, 3'd1, 8'hFF);
    mem[1] = encI8(OP_SLH, 3'd1, 8'h7F);
    mem[2] = encI8(OP_SLL, 3'd2, 8'h01);
    mem[3] = encR(OP_ADD, 3'd3, 3'd1, 3'd2);
  endtask

  initial begin
    logic [15:0] slhWord;
    int          fetches;

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    // Reset values while reset is held
    #3;
    checkOutput("rst_rd", 32'(RD), 32'd0);
    checkOutput("rst_wr", 32'(WR), 32'd0);
    checkOutput("rst_addr", 32'(Addr), 32'd0);
    checkOutput("rst_dataout", 32'(DataOut), 32'd0);
    checkOutput("rst_v", 32'(V), 32'd0);

    // Byte loads and a store, then HALT
    $display("[TB] test 1: SLL/SLH/ST/HALT");
    clearProg();
    mem[0] = encI8(OP_SLL, 3'd1, 8'h34);
    mem[1] = encI8(OP_SLH, 3'd1, 8'h12);
    mem[2] = encM(OP_ST, 3'd1, 3'd0, 6'd5);
    mem[3] = encJ(OP_HALT, 12'h000);
    pushWrite(16'h0005, 16'h1234, 8);
    applyStimulus(40);
    @(negedge Clk1);
    checkOutput("t1_mem5", 32'(mem[5]), 32'h1234);
    checkOutput("t1_halt_fetch_cyc", 32'(lastRdCyc), 32'd9);
    checkOutput("t1_halt_rd", 32'(RD), 32'd0);
    checkOutput("t1_halt_wr", 32'(WR), 32'd0);
    checkOutput("t1_v", 32'(V), 32'd0);
    checkOutput("t1_sb_drained", 32'(sbq.size()), 32'd0);

    // Signed overflow on ADD
    $display("[TB] test 2: ADD overflow");
    clearProg();
    loadOverflowPrefix();
    mem[4] = encM(OP_ST, 3'd3, 3'd0, 6'h10);
    mem[5] = encJ(OP_HALT, 12'h000);
    pushWrite(16'h0010, OVF_RESULT, 14);
    applyStimulus(40);
    @(negedge Clk1);
    checkOutput("t2_v_set", 32'(V), 32'd1);
    checkOutput("t2_halt_fetch_cyc", 32'(lastRdCyc), 32'd15);
    checkOutput("t2_sb_drained", 32'(sbq.size()), 32'd0);

    // Following non-overflowing ADD clears V
    $display("[TB] test 2b: ADD clears V");
    mem[5] = encR(OP_ADD, 3'd4, 3'd2, 3'd2);
    mem[6] = encM(OP_ST, 3'd4, 3'd0, 6'h11);
    mem[7] = encJ(OP_HALT, 12'h000);
    pushWrite(16'h0010, OVF_RESULT, 14);
    pushWrite(16'h0011, 16'h0002, 20);
    applyStimulus(40);
    @(negedge Clk1);
    checkOutput("t2b_v_clear", 32'(V), 32'd0);
    checkOutput("t2b_halt_fetch_cyc", 32'(lastRdCyc), 32'd21);
    checkOutput("t2b_sb_drained", 32'(sbq.size()), 32'd0);

    // Vector load, add, store
    $display("[TB] test 3: VLD/VADD/VST");
    clearProg();
    mem[16'h40] = 16'd1;
    mem[16'h41] = 16'd2;
    mem[16'h42] = 16'd3;
    mem[16'h43] = 16'd4;
    mem[0] = encI8(OP_SLL, 3'd4, 8'h40);
    mem[1] = encI8(OP_SLL, 3'd5, 8'h50);
    mem[2] = encM(OP_VLD, 3'd0, 3'd4, 6'd0);
    mem[3] = encR(OP_VADD, 3'd1, 3'd0, 3'd0);
    mem[4] = encM(OP_VST, 3'd1, 3'd5, 6'd0);
    mem[5] = encJ(OP_HALT, 12'h000);
    for (int k = 0; k < 4; k++)
      pushWrite(16'h0050 + 16'(k), 16'(2 * (k + 1)), 21 + k);
    applyStimulus(50);
    @(negedge Clk1);
    checkOutput("t3_halt_fetch_cyc", 32'(lastRdCyc), 32'd25);
    checkOutput("t3_mem53", 32'(mem[16'h53]), 32'd8);
    checkOutput("t3_v", 32'(V), 32'd0);
    checkOutput("t3_sb_drained", 32'(sbq.size()), 32'd0);

    // BOV taken, BOV not taken, J to itself
    $display("[TB] test 4: BOV/J");
    clearProg();
    loadOverflowPrefix();
    mem[4]  = encJ(OP_BOV, 12'd2);
    mem[5]  = encM(OP_ST, 3'd2, 3'd0, 6'h18);
    mem[6]  = encM(OP_ST, 3'd2, 3'd0, 6'h19);
    mem[7]  = encR(OP_ADD, 3'd4, 3'd2, 3'd2);
    mem[8]  = encJ(OP_BOV, 12'd2);
    mem[9]  = encM(OP_ST, 3'd4, 3'd0, 6'h1A);
    mem[10] = encJ(OP_J, 12'hFFF);
    pushWrite(16'h001A, 16'h0002, 23);
    applyStimulus(40);
    fetches = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk1);
      if (RD) begin
        fetches++;
        checkOutput("t4_jloop_addr", 32'(Addr), 32'd10);
      end
    end
    checkOutput("t4_jloop_fetches", 32'(fetches), 32'd2);
    checkOutput("t4_skipped_18", 32'(mem[16'h18]), 32'd0);
    checkOutput("t4_skipped_19", 32'(mem[16'h19]), 32'd0);
    checkOutput("t4_v", 32'(V), 32'd0);
    checkOutput("t4_sb_drained", 32'(sbq.size()), 32'd0);

    // Reset during a VST after two elements were written
    $display("[TB] test 5: reset mid-VST");
    clearProg();
    for (int k = 0; k < 4; k++) mem[16'h60 + 16'(k)] = 16'hDEAD;
    mem[0] = encI8(OP_SLL, 3'd4, 8'h40);
    mem[1] = encI8(OP_SLL, 3'd5, 8'h60);
    mem[2] = encM(OP_VLD, 3'd0, 3'd4, 6'd0);
    mem[3] = encM(OP_VST, 3'd0, 3'd5, 6'd0);
    mem[4] = encJ(OP_HALT, 12'h000);
    pushWrite(16'h0060, 16'd1, 18);
    pushWrite(16'h0061, 16'd2, 19);
    applyStimulus(20);
    Reset = 1'b0;
    @(negedge Clk1);
    checkOutput("t5_rst_rd", 32'(RD), 32'd0);
    checkOutput("t5_rst_wr", 32'(WR), 32'd0);
    checkOutput("t5_mem60", 32'(mem[16'h60]), 32'd1);
    checkOutput("t5_mem61", 32'(mem[16'h61]), 32'd2);
    checkOutput("t5_mem62", 32'(mem[16'h62]), 32'hDEAD);
    checkOutput("t5_mem63", 32'(mem[16'h63]), 32'hDEAD);
    checkOutput("t5_sb_drained", 32'(sbq.size()), 32'd0);
    @(posedge Clk1);
    #1 Reset = 1'b1;
    @(negedge Clk1);
    checkOutput("t5_refetch_addr", 32'(Addr), 32'd0);
    checkOutput("t5_refetch_wr", 32'(WR), 32'd0);
    Reset = 1'b0;

    // LD address wraps past FFFF
    $display("[TB] test 6: LD address wrap");
    clearProg();
    mem[0] = encI8(OP_SLL, 3'd1, 8'hFF);
    mem[1] = encI8(OP_SLH, 3'd1, 8'hFF);
    mem[2] = encM(OP_LD, 3'd2, 3'd1, 6'd2);
    mem[3] = encM(OP_ST, 3'd2, 3'd0, 6'h1C);
    mem[4] = encJ(OP_HALT, 12'h000);
    slhWord = encI8(OP_SLH, 3'd1, 8'hFF);
    pushWrite(16'h001C, slhWord, 12);
    applyStimulus(40);
    @(negedge Clk1);
    checkOutput("t6_halt_fetch_cyc", 32'(lastRdCyc), 32'd13);
    checkOutput("t6_sb_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
